// File: rtl/imem_rom_if.sv
// Fetch bus between the PC logic (master, drives the word address) and the
// instruction ROM (slave, returns the instruction word).
interface imem_rom_if #(
    parameter int unsigned N = 32
);
    logic [5:0]   addr;
    logic [N-1:0] q;

    modport master (output addr, input  q);
    modport slave  (input  addr, output q);
endinterface

// File: rtl/imem_rom.sv
// Read-only 64-word LEGv8 instruction memory holding the fixed test program.
// Purely combinational lookup; clk/reset exist only for interface uniformity.
module imem_rom #(
    parameter int unsigned N = 32
) (
    input  logic       clk,
    input  logic       reset,
    imem_rom_if.slave  bus
);

    // clk and reset deliberately have no effect on the read path
    logic unused_clk_reset;
    assign unused_clk_reset = &{1'b0, clk, reset};

    logic [31:0] word;

    always_comb begin
        word = '0;
        unique case (bus.addr)
            6'd0:  word = 32'hf8000001;
            6'd1:  word = 32'hf8008002;
            6'd2:  word = 32'hf8000203;
            6'd3:  word = 32'h8b050083;
            6'd4:  word = 32'hf8018003;
            6'd5:  word = 32'hcb050083;
            6'd6:  word = 32'hf8020003;
            6'd7:  word = 32'hcb0a03e4;
            6'd8:  word = 32'hf8028004;
            6'd9:  word = 32'h8b040064;
            6'd10: word = 32'hf8030004;
            6'd11: word = 32'hcb030025;
            6'd12: word = 32'hf8038005;
            6'd13: word = 32'h8a1f0145;
            6'd14: word = 32'hf8040005;
            6'd15: word = 32'h8a030145;
            6'd16: word = 32'hf8048005;
            6'd17: word = 32'h8a140294;
            6'd18: word = 32'hf8050014;
            6'd19: word = 32'haa1f0166;
            6'd20: word = 32'hf8058006;
            6'd21: word = 32'haa030166;
            6'd22: word = 32'hf8060006;
            6'd23: word = 32'hf840000c;
            6'd24: word = 32'h8b1f0187;
            6'd25: word = 32'hf8068007;
            6'd26: word = 32'hf807000c;
            6'd27: word = 32'h8b0e01bf;
            6'd28: word = 32'hf807801f;
            6'd29: word = 32'hb4000040;  // CBZ forward branch
            6'd30: word = 32'hf8080015;
            6'd31: word = 32'hf8088015;
            6'd32: word = 32'h8b0103e2;
            6'd33: word = 32'hcb010042;
            6'd34: word = 32'h8b0103f8;
            6'd35: word = 32'hf8090018;
            6'd36: word = 32'h8b080000;
            6'd37: word = 32'hb4ffff82;  // CBZ X2, -4 words (loop back to 33)
            6'd38: word = 32'hf809001e;
            6'd39: word = 32'h8b1e03de;
            6'd40: word = 32'hcb1503f5;
            6'd41: word = 32'h8b1403de;
            6'd42: word = 32'hf85f83d9;
            6'd43: word = 32'h8b1e03de;
            6'd44: word = 32'h8b1003de;
            6'd45: word = 32'hf81f83d9;
            6'd46: word = 32'hb400001f;  // CBZ XZR, finloop (terminal self-loop)
            default: word = '0;
        endcase
    end

    assign bus.q = N'(word);

endmodule

// File: tb/tb_imem_rom.sv
// Directed self-checking bench for imem_rom: sweep, empty region, branch words,
// reset independence, clock-free combinational path and random access.
module tb_imem_rom;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clk_run = 1'b1;
    int   checks = 0;
    int   failures = 0;

    imem_rom_if #(.N(32)) bus ();

    imem_rom #(.N(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 if (clk_run) clk = ~clk;

    logic [31:0] golden [64];

    initial begin
        golden = '{
            32'hf8000001, 32'hf8008002, 32'hf8000203, 32'h8b050083,
            32'hf8018003, 32'hcb050083, 32'hf8020003, 32'hcb0a03e4,
            32'hf8028004, 32'h8b040064, 32'hf8030004, 32'hcb030025,
            32'hf8038005, 32'h8a1f0145, 32'hf8040005, 32'h8a030145,
            32'hf8048005, 32'h8a140294, 32'hf8050014, 32'haa1f0166,
            32'hf8058006, 32'haa030166, 32'hf8060006, 32'hf840000c,
            32'h8b1f0187, 32'hf8068007, 32'hf807000c, 32'h8b0e01bf,
            32'hf807801f, 32'hb4000040, 32'hf8080015, 32'hf8088015,
            32'h8b0103e2, 32'hcb010042, 32'h8b0103f8, 32'hf8090018,
            32'h8b080000, 32'hb4ffff82, 32'hf809001e, 32'h8b1e03de,
            32'hcb1503f5, 32'h8b1403de, 32'hf85f83d9, 32'h8b1e03de,
            32'h8b1003de, 32'hf81f83d9, 32'hb400001f, 32'h00000000,
            32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
            32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
            32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
            32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000
        };
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: q=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input logic [5:0] a, input string tag, input logic [31:0] exp);
        @(negedge clk);
        bus.addr = a;
        @(posedge clk);
        #1;
        check($sformatf("%s[%0d]", tag, a), bus.q, exp);
    endtask

    initial begin
        logic [5:0] ra;
        bus.addr = 6'd0;
        #2;
        // q under reset already reflects the addressed word
        check("reset_state_addr0", bus.q, 32'hf8000001);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i <= 46; i++) fetch(6'(i), "sweep", golden[i]);
        fetch(6'd3,  "spot", 32'h8b050083);
        fetch(6'd23, "spot", 32'hf840000c);
        fetch(6'd46, "spot", 32'hb400001f);

        fetch(6'd47, "empty", 32'h00000000);
        fetch(6'd48, "empty", 32'h00000000);
        fetch(6'd49, "empty", 32'h00000000);
        fetch(6'd63, "empty", 32'h00000000);

        fetch(6'd29, "branch", 32'hb4000040);
        fetch(6'd37, "branch", 32'hb4ffff82);
        fetch(6'd42, "branch", 32'hf85f83d9);

        @(negedge clk);
        bus.addr = 6'd9;
        #1 reset = 1'b1;
        #1 check("rst_hi", bus.q, 32'h8b040064);
        #1 reset = 1'b0;
        #1 check("rst_lo", bus.q, 32'h8b040064);
        #1 reset = 1'b1;
        #1 check("rst_hi2", bus.q, 32'h8b040064);
        @(posedge clk);
        #1 check("rst_edge", bus.q, 32'h8b040064);
        reset = 1'b0;

        @(negedge clk);
        clk_run = 1'b0;
        bus.addr = 6'd5;
        #1 check("comb_addr5", bus.q, 32'hcb050083);
        bus.addr = 6'd40;
        #1 check("comb_addr40", bus.q, 32'hcb1503f5);
        bus.addr = 6'd0;
        #1 check("comb_addr0", bus.q, 32'hf8000001);
        check("comb_clk_still", {31'b0, clk}, 32'h0);
        clk_run = 1'b1;

        for (int i = 0; i < 200; i++) begin
            ra = 6'($urandom_range(0, 63));
            fetch(ra, "rand", golden[ra]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_rom.md
# imem_rom

Read-only instruction memory for the single-cycle LEGv8 processor. It holds the fixed 64-word test program and returns the 32-bit instruction word at the given word address. It sits between the PC logic, which supplies the address, and the instruction decoder, which consumes `q`. The read path is purely combinational. The clock and reset ports exist only so the block matches the processor's common interface.

## Interface
Parameters:
- `N`, default 32: instruction word width. Only 32 is supported.

Ports:
- `clk`, input, 1: system clock. One clock; not used by the read path.
- `reset`, input, 1: reset. Asynchronous and active-high; has no effect on `q`.
- `addr`, input, 6: word index, 0–63. This is a word address, not a byte address; the PC-to-index conversion is done upstream.
- `q`, output, N (32): instruction word stored at `addr`.

## Operation
- `q = ROM[addr]`, combinational; the block holds no state.
- The ROM is initialised at elaboration and is never written.
- Contents (hex, by address):
  - 0–7: f8000001 f8008002 f8000203 8b050083 f8018003 cb050083 f8020003 cb0a03e4
  - 8–15: f8028004 8b040064 f8030004 cb030025 f8038005 8a1f0145 f8040005 8a030145
  - 16–23: f8048005 8a140294 f8050014 aa1f0166 f8058006 aa030166 f8060006 f840000c
  - 24–31: 8b1f0187 f8068007 f807000c 8b0e01bf f807801f b4000040 f8080015 f8088015
  - 32–39: 8b0103e2 cb010042 8b0103f8 f8090018 8b080000 b4ffff82 f809001e 8b1e03de
  - 40–46: cb1503f5 8b1403de f85f83d9 8b1e03de 8b1003de f81f83d9 b400001f
  - 47–63: 00000000
- Program summary:
  - STUR/ADD/SUB/AND/ORR/LDUR exercise sequence.
  - CBZ forward branch at word 29.
  - Loop at words 33–37 (CBZ X2, −4 words).
  - Terminal self-loop `CBZ XZR, finloop` at word 46.
- All 64 addresses are legal. There is no out-of-range case, no wrap-around logic, and no X output for any defined `addr`.
- `q` never contains X or Z once `addr` is known.

## Timing
- Latency is zero cycles: `q` settles within combinational delay of an `addr` change, independent of `clk` edges.
- `reset` asserted or deasserted at any time, including mid-fetch, leaves `q` equal to `ROM[addr]`; there is no reset value distinct from the addressed word.
- The processor drives `addr` from the PC register after the rising edge. `q` must be stable before the next rising edge, so the ROM lookup counts as part of the single-cycle critical path.
- Any change to `addr`, including one in the middle of a cycle, is reflected on `q` without waiting for a clock edge.

## Test plan
- Sequential sweep: drive `addr` 0..46, one per cycle, changing on the negedge and checking 1 ns after the posedge.
  - Every `q` must equal the table above, for example 0 → f8000001, 3 → 8b050083, 23 → f840000c, 46 → b400001f.
  - Required result: 0 errors.
- Empty region: `addr` 47, 48, 49 and 63 → `q` = 00000000 each.
- Branch words: `addr` 29 → b4000040; `addr` 37 → b4ffff82; `addr` 42 → f85f83d9 (negative-offset LDUR).
- Reset independence: hold `addr` = 9 and toggle `reset` 1 → 0 → 1 asynchronously between clock edges → `q` stays 8b040064 throughout.
- Combinational path: with `clk` held still, change `addr` from 5 to 40 → `q` changes from cb050083 to cb1503f5 within the same time step, with no clock edge.
- Random access: apply 200 random `addr` values in 0..63 → each `q` matches the golden table, and no X/Z ever appears on `q`.
